sram_sync: RTL and testbench
============================

SRAM_SYNC -- requirements
Module: sram_sync

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, word width in bits, a multiple of 8.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 The module SHALL have parameter RAM_DEPTH, default 256, number of words, 1..2^ADDR_WIDTH.
REQ-004 The module SHALL have parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written to every location by the clear sweep.
REQ-005 The module SHALL have port clock, input, 1, the only clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 The module SHALL have port request_valid, input, 1, request present.
REQ-008 The module SHALL have port request_ready, output, 1, request accepted when both request_valid and request_ready are high at a rising edge.
REQ-009 The module SHALL have port request_write, input, 1, 1 = write, 0 = read.
REQ-010 The module SHALL have port address, input, ADDR_WIDTH, word address.
REQ-011 The module SHALL have port write_data, input, DATA_WIDTH, write word.
REQ-012 The module SHALL have port byte_enable, input, DATA_WIDTH/8, per-byte write mask; bit i covers bits 8i+7:8i.
REQ-013 The module SHALL have port read_valid, output, 1, one-cycle pulse marking valid read_data.
REQ-014 The module SHALL have port read_data, output, DATA_WIDTH, read word.
REQ-015 The module SHALL have port clear_busy, output, 1, high while the clear sweep runs.

Function
REQ-016 The state machine SHALL have states CLEAR and READY.
REQ-017 In CLEAR, a sweep counter SHALL write CLEAR_VALUE to one address per cycle, from 0 to RAM_DEPTH-1, and then move to READY.
REQ-018 A sweep SHALL take exactly RAM_DEPTH cycles; clear_busy SHALL be high for exactly those cycles.
REQ-019 request_ready SHALL equal 1 in READY and 0 in CLEAR; requests offered during CLEAR SHALL be ignored.
REQ-020 An accepted write SHALL update only the bytes whose byte_enable bit is 1; a write with byte_enable all-zero SHALL leave memory unchanged.
REQ-021 An accepted read SHALL assert read_valid exactly one cycle later, with read_data = mem[address] captured at acceptance.
REQ-022 Back-to-back accepted requests SHALL sustain one request per cycle with no bubbles.
REQ-023 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-024 Write accepted at address >= RAM_DEPTH: SHALL be discarded. Read accepted at address >= RAM_DEPTH: SHALL return read_data = 0 with read_valid = 1.
REQ-025 read_data SHALL hold its last value when read_valid is 0.
REQ-026 Writes SHALL NOT produce a read_valid pulse.

Reset
REQ-027 While reset = 1 at a rising edge, the following SHALL apply: state = CLEAR, sweep counter = 0, read_valid = 0, read_data = 0, request_ready = 0, clear_busy = 1.
REQ-028 The first sweep write SHALL occur on the first rising edge with reset = 0.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-030 Reset asserted in READY SHALL cancel any pending read_valid.

Configuration
REQ-031 With macro SRAM_SYNC_PARITY_EN defined, each word SHALL store one even-parity bit per byte, recomputed on every write and the sweep.
REQ-032 With SRAM_SYNC_PARITY_EN defined, there SHALL be an output parity_error, 1 bit, pulsed alongside read_valid when any stored byte parity mismatches; reset value 0.
REQ-033 With SRAM_SYNC_PARITY_EN defined, the memory array SHALL be DATA_WIDTH + DATA_WIDTH/8 bits wide.
REQ-034 Without SRAM_SYNC_PARITY_EN, no parity storage and no parity_error port SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-035 Defaults; release reset -> clear_busy high for 256 cycles, request_ready rises on cycle 257; reading address 124 returns 16'h0000.
REQ-036 Write 16'h3779 to address 124 with byte_enable 2'b11, then read next cycle -> read_valid one cycle after the read; read_data = 16'h3779.
REQ-037 Write 16'hAAAA to address 242, then write 16'h0078 with byte_enable 2'b01, then read -> 16'hAA78.
REQ-038 Assert reset at sweep address 100, release -> sweep restarts at 0; clear_busy high for 256 cycles; a request_valid held high is not accepted until READY.
REQ-039 RAM_DEPTH=200, ADDR_WIDTH=8: write 16'h1234 to address 210 then read it -> read_data = 0; address 0 remains CLEAR_VALUE.
REQ-040 With SRAM_SYNC_PARITY_EN defined: force-flip one stored data bit at address 5, then read -> parity_error = 1 in the same cycle as read_valid. A clean word gives parity_error = 0.

Source files
------------

// File: rtl/sram_sync_if.sv
// Request/response bundle for sram_sync. parity_error exists only when
// SRAM_SYNC_PARITY_EN is defined.
interface sram_sync_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                    request_valid;
  logic                    request_ready;
  logic                    request_write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] byte_enable;
  logic                    read_valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    clear_busy;
`ifdef SRAM_SYNC_PARITY_EN
  logic                    parity_error;

  modport master (
    output request_valid, request_write, address, write_data, byte_enable,
    input  request_ready, read_valid, read_data, clear_busy, parity_error
  );
  modport slave (
    input  request_valid, request_write, address, write_data, byte_enable,
    output request_ready, read_valid, read_data, clear_busy, parity_error
  );
`else
  modport master (
    output request_valid, request_write, address, write_data, byte_enable,
    input  request_ready, read_valid, read_data, clear_busy
  );
  modport slave (
    input  request_valid, request_write, address, write_data, byte_enable,
    output request_ready, read_valid, read_data, clear_busy
  );
`endif
endinterface

// File: rtl/sram_sync.sv
// Single-port synchronous SRAM with byte enables and a post-reset clear sweep.
// Optional per-byte even parity with SRAM_SYNC_PARITY_EN.
module sram_sync #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    RAM_DEPTH   = 256,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic       clock,
  input  logic       reset,
  sram_sync_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
`ifdef SRAM_SYNC_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + NB;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef SRAM_SYNC_PARITY_EN
    return {byte_parity(d), d};
`else
    return d;
`endif
  endfunction

  localparam logic [MEM_W-1:0] CLEAR_WORD = encode(CLEAR_VALUE);

  logic [MEM_W-1:0]      r_mem [RAM_DEPTH];
  state_t                r_state;
  logic [IDX_W-1:0]      r_sweep;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [MEM_W-1:0]      w_rd_word;

  assign w_accept   = bus.request_valid & r_ready;
  assign w_in_range = ({1'b0, bus.address} < DEPTH_L);
  assign w_idx      = bus.address[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];

  // Storage has no reset; the sweep is what initialises it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_sweep] <= CLEAR_WORD;
      end else if (w_accept && bus.request_write && w_in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.byte_enable[b]) begin
            r_mem[w_idx][8*b +: 8] <= bus.write_data[8*b +: 8];
`ifdef SRAM_SYNC_PARITY_EN
            r_mem[w_idx][DATA_WIDTH+b] <= ^bus.write_data[8*b +: 8];
`endif
          end
        end
      end
    end
  end

`ifdef SRAM_SYNC_PARITY_EN
  logic r_perr;
  logic w_perr;

  // Any byte whose stored bits plus parity bit come out odd is corrupt.
  assign w_perr = |(byte_parity(w_rd_word[DATA_WIDTH-1:0]) ^ w_rd_word[MEM_W-1:DATA_WIDTH]);

  always_ff @(posedge clock) begin
    if (reset)
      r_perr <= 1'b0;
    else
      r_perr <= w_accept && !bus.request_write && w_in_range && w_perr;
  end

  assign bus.parity_error = r_perr;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= CLEAR;
      r_sweep  <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        CLEAR: begin
          if (r_sweep == LAST_IDX) begin
            r_state <= READY;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + 1'b1;
          end
        end
        READY: begin
          if (w_accept && !bus.request_write) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_in_range ? w_rd_word[DATA_WIDTH-1:0] : '0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign bus.request_ready = r_ready;
  assign bus.clear_busy    = r_busy;
  assign bus.read_valid    = r_rvalid;
  assign bus.read_data     = r_rdata;
endmodule

// File: tb/tb_sram_sync.sv
// Randomized bench for sram_sync against an array model; a second instance
// with RAM_DEPTH=200 covers out-of-range addressing.
module tb_sram_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();
  sram_sync_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus2 ();

  sram_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(256), .CLEAR_VALUE(16'h0000))
    dut (.clock(clk), .reset(rst), .bus(bus.slave));
  sram_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(200), .CLEAR_VALUE(16'h0000))
    dut200 (.clock(clk), .reset(rst), .bus(bus2.slave));

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] model [256];
  logic [15:0] last_rd = 16'h0;
  logic [15:0] last_rd2 = 16'h0;
  bit          mdl_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
  endtask

  // One cycle on the main instance: drive, clock, check against the model.
  task automatic op(input bit v, input bit w, input logic [7:0] a,
                    input logic [15:0] d, input logic [1:0] be);
    bit acc;
    bus.request_valid = v;
    bus.request_write = w;
    bus.address       = a;
    bus.write_data    = d;
    bus.byte_enable   = be;
    acc = v && mdl_ready;
    chk("ready", bus.request_ready, mdl_ready);
    tick();
    if (acc && !w) last_rd = model[a];
    if (acc && w) begin
      if (be[0]) model[a][7:0]  = d[7:0];
      if (be[1]) model[a][15:8] = d[15:8];
    end
    chk("rvalid", bus.read_valid, acc && !w);
    chk("rdata", bus.read_data, last_rd);
`ifdef SRAM_SYNC_PARITY_EN
    chk("perr", bus.parity_error, 1'b0);
`endif
    bus.request_valid = 1'b0;
  endtask

  task automatic op2(input bit w, input logic [7:0] a, input logic [15:0] d);
    bus2.request_valid = 1'b1;
    bus2.request_write = w;
    bus2.address       = a;
    bus2.write_data    = d;
    bus2.byte_enable   = 2'b11;
    tick();
    if (!w) last_rd2 = (a < 200) ? last_rd2 : 16'h0;
    bus2.request_valid = 1'b0;
  endtask

  // Called right after reset release; a read of `a` is held pending throughout.
  task automatic sweep_check(input string tag, input logic [7:0] a);
    int busy_n = 0;
    int cyc    = 0;
    int bad    = 0;
    bus.request_valid = 1'b1;
    bus.request_write = 1'b0;
    bus.address       = a;
    while (bus.request_ready !== 1'b1 && cyc < 1000) begin
      if (bus.clear_busy === 1'b1) busy_n++;
      if (bus.read_valid !== 1'b0 || bus.request_ready !== 1'b0) bad++;
      tick();
      cyc++;
    end
    chk({tag, "_cycles"}, cyc, 256);
    chk({tag, "_busy"}, busy_n, 256);
    chk({tag, "_ignored"}, bad, 0);
    chk({tag, "_busy_low"}, bus.clear_busy, 1'b0);
    mdl_ready = 1'b1;
    tick();
    last_rd = model[a];
    chk({tag, "_rvalid"}, bus.read_valid, 1'b1);
    chk({tag, "_rdata"}, bus.read_data, last_rd);
    bus.request_valid = 1'b0;
  endtask

  initial begin
    bus.request_valid  = 1'b0;
    bus.request_write  = 1'b0;
    bus.address        = '0;
    bus.write_data     = '0;
    bus.byte_enable    = '0;
    bus2.request_valid = 1'b0;
    bus2.request_write = 1'b0;
    bus2.address       = '0;
    bus2.write_data    = '0;
    bus2.byte_enable   = '0;
    model_clear();

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.clear_busy, 1'b1);
    chk("rst_ready", bus.request_ready, 1'b0);
    chk("rst_rvalid", bus.read_valid, 1'b0);
    chk("rst_rdata", bus.read_data, 16'h0);

    // Abort a sweep around address 100 and make sure it restarts from 0.
    rst = 1'b0;
    repeat (100) tick();
    chk("mid_busy", bus.clear_busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", bus.clear_busy, 1'b1);
    chk("mid_rst_ready", bus.request_ready, 1'b0);
    rst = 1'b0;
    sweep_check("sweep1", 8'd124);
    chk("clear_124", bus.read_data, 16'h0000);

    op(1, 1, 8'd124, 16'h3779, 2'b11);
    op(1, 0, 8'd124, 16'h0, 2'b00);
    chk("wr_rd_124", bus.read_data, 16'h3779);
    op(1, 1, 8'd242, 16'hAAAA, 2'b11);
    op(1, 1, 8'd242, 16'h0078, 2'b01);
    op(1, 0, 8'd242, 16'h0, 2'b00);
    chk("be_242", bus.read_data, 16'hAA78);
    op(1, 1, 8'd242, 16'hFFFF, 2'b00);
    op(0, 0, 8'd0, 16'h0, 2'b00);
    op(1, 0, 8'd242, 16'h0, 2'b00);
    chk("be0_242", bus.read_data, 16'hAA78);

    for (int i = 0; i < 400; i++)
      op($urandom_range(0, 9) < 8, 1'($urandom), 8'($urandom), 16'($urandom), 2'($urandom));

    // Out-of-range handling on the shallow instance.
    chk("d200_ready", bus2.request_ready, 1'b1);
    op2(1'b1, 8'd210, 16'h1234);
    chk("d200_wr_norv", bus2.read_valid, 1'b0);
    op2(1'b0, 8'd210, 16'h0);
    chk("d200_oor_rv", bus2.read_valid, 1'b1);
    chk("d200_oor_rd", bus2.read_data, 16'h0000);
    op2(1'b1, 8'd199, 16'h55AA);
    op2(1'b0, 8'd199, 16'h0);
    chk("d200_199", bus2.read_data, 16'h55AA);
    op2(1'b0, 8'd0, 16'h0);
    chk("d200_addr0", bus2.read_data, 16'h0000);

`ifdef SRAM_SYNC_PARITY_EN
    op(1, 1, 8'd5, 16'h1357, 2'b11);
    dut.r_mem[5][0] = ~dut.r_mem[5][0];
    bus.request_valid = 1'b1;
    bus.request_write = 1'b0;
    bus.address       = 8'd5;
    tick();
    bus.request_valid = 1'b0;
    chk("par_rv", bus.read_valid, 1'b1);
    chk("par_err", bus.parity_error, 1'b1);
    chk("par_data", bus.read_data, 16'h1356);
    last_rd = 16'h1356;
    op(1, 0, 8'd6, 16'h0, 2'b00);
`endif

    // Reset in READY with a read offered on the same edge: no pulse survives.
    bus.request_valid = 1'b1;
    bus.request_write = 1'b0;
    bus.address       = 8'd124;
    rst = 1'b1;
    tick();
    mdl_ready = 1'b0;
    chk("rr_rvalid", bus.read_valid, 1'b0);
    chk("rr_rdata", bus.read_data, 16'h0);
    chk("rr_busy", bus.clear_busy, 1'b1);
    chk("rr_ready", bus.request_ready, 1'b0);
    model_clear();
    last_rd = 16'h0;
    rst = 1'b0;
    sweep_check("sweep2", 8'd124);
    for (int i = 0; i < 60; i++)
      op(1'b1, 1'($urandom), 8'($urandom_range(120, 127)), 16'($urandom), 2'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
